imem_stream_loader: RTL and testbench

- Writer side of the pipeline's instruction memory; the pipeline only ever reads that memory.
- Receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through a write port.
- Holds the pipeline in reset until a complete frame with a correct checksum has been loaded.

---
 rtl/imem_stream_loader.sv | 189 ++++++++++++++++++
 tb/tb_imem_stream_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_stream_loader
// Purpose  : Receives a framed byte stream (SYNC, N, N*4 payload bytes,
//            8-bit sum checksum), assembles little-endian 32-bit words and
//            writes them into the instruction memory. The pipeline is held
//            in reset until a frame with a matching checksum is loaded.
// Options  : LOADER_TIMEOUT_EN - abort a stalled frame after TIMEOUT idle
//            cycles in COUNT/DATA/CHECK.
// Revision : 1.0 - initial release
// ============================================================================
module imem_stream_loader #(
    parameter int         DEPTH     = 16,
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 1024
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    // Word count is compared unsigned against DEPTH with one spare bit so
    // that DEPTH values up to 256 never truncate.
    localparam logic [8:0] c_DEPTH_9 = 9'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_in_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_word_idx;
    logic [ADDR_W-1:0] r_last_idx;
    logic [1:0]        r_lane;
    logic [23:0]       r_word;
    logic [7:0]        r_sum;

    logic              w_accept;
    logic              w_count_bad;
    logic              w_last_byte;
    logic              w_timeout;

    assign w_accept    = in_valid && r_in_ready;
    assign w_count_bad = (in_data == 8'd0) || ({1'b0, in_data} > c_DEPTH_9);
    assign w_last_byte = (r_lane == 2'd3) && (r_word_idx == r_last_idx);

`ifdef LOADER_TIMEOUT_EN
    localparam int                 c_TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               w_frame_active;

    assign w_frame_active = (r_state == S_COUNT) || (r_state == S_DATA) ||
                            (r_state == S_CHECK);
    assign w_timeout      = w_frame_active && !w_accept && (r_tmo_cnt == c_TMO_LAST);

    // Idle-cycle counter: cleared by any accepted byte or outside a frame.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_tmo_cnt <= '0;
        end else if (w_accept || !w_frame_active) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode on accepted bytes, plus status outputs from state.
    always_comb begin
        w_next    = r_state;
        done      = 1'b0;
        error     = 1'b0;
        cpu_reset = 1'b1;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_accept && (in_data == SYNC_BYTE)) begin
                    w_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (w_accept) begin
                    w_next = w_count_bad ? S_ERROR : S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept && w_last_byte) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_accept) begin
                    w_next = (in_data == r_sum) ? S_DONE : S_ERROR;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_timeout) begin
            w_next = S_ERROR;
        end
        if (r_state == S_DONE) begin
            done      = 1'b1;
            cpu_reset = 1'b0;
        end
        if (r_state == S_ERROR) begin
            error = 1'b1;
        end
    end

    // Datapath: frame bookkeeping, word assembly, checksum and write port.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_word_idx <= '0;
            r_last_idx <= '0;
            r_lane     <= '0;
            r_word     <= '0;
            r_sum      <= '0;
        end else begin
            r_in_ready <= 1'b1;
            r_we       <= 1'b0;
            if ((r_state == S_COUNT) && w_accept) begin
                // N is already range-checked, so N-1 fits the address width.
                r_last_idx <= ADDR_W'(in_data - 8'd1);
                r_word_idx <= '0;
                r_lane     <= '0;
                r_sum      <= '0;
            end
            if ((r_state == S_DATA) && w_accept) begin
                r_sum  <= r_sum + in_data;
                r_lane <= r_lane + 2'd1;
                case (r_lane)
                    2'd0: r_word[7:0]   <= in_data;
                    2'd1: r_word[15:8]  <= in_data;
                    2'd2: r_word[23:16] <= in_data;
                    default: begin
                        r_we       <= 1'b1;
                        r_addr     <= r_word_idx;
                        r_wdata    <= {in_data, r_word};
                        r_word_idx <= r_word_idx + ADDR_W'(1);
                    end
                endcase
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_stream_loader
// Purpose  : Directed self-checking bench for imem_stream_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_stream_loader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          we_cnt   = 0;
    logic [31:0] tb_mem [16];

    always #5 clock = ~clock;

    imem_stream_loader #(
        .DEPTH    (16),
        .ADDR_W   (4),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT  (8)
    ) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    // Record every write strobe into a shadow of the instruction memory.
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            we_cnt = we_cnt + 1;
            tb_mem[imem_addr] = imem_wdata;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Present one byte for one cycle, then idle for gap cycles.
    task automatic send(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (gap) @(negedge clock);
    endtask

    // The two-word frame body (sync, count, 8 payload bytes), no checksum.
    task automatic send_two_word_body(input int gap);
        logic [7:0] fr [10] = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h50,
                                8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
        for (int i = 0; i < 10; i++) send(fr[i], gap);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick(3);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_imem_we: got %b want 0", imem_we); end
        n_checks++; if (imem_addr !== 4'h0) begin n_fail++; $display("FAIL rst_imem_addr: got %h want 0", imem_addr); end
        n_checks++; if (imem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_imem_wdata: got %h want 0", imem_wdata); end
        n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b want 0", error); end
        reset_n = 1'b1;
        tick(1);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
        n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rel_cpu_reset: got %b want 1", cpu_reset); end
    endtask

    task automatic test_two_word();
        we_cnt = 0;
        send(8'h3C, 0);
        send(8'hFF, 0);
        send_two_word_body(0);
        n_checks++; if (done !== 1'b0 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL two_pre_ck: got done=%b cpu_reset=%b want 0/1", done, cpu_reset); end
        send(8'h97, 0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL two_done: got %b want 1", done); end
        n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL two_cpu_reset: got %b want 0", cpu_reset); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL two_error: got %b want 0", error); end
        tick(2);
        n_checks++; if (we_cnt !== 2) begin n_fail++; $display("FAIL two_we_cnt: got %0d want 2", we_cnt); end
        n_checks++; if (tb_mem[0] !== 32'h00500093) begin n_fail++; $display("FAIL two_word0: got %h want 00500093", tb_mem[0]); end
        n_checks++; if (tb_mem[1] !== 32'h00A00113) begin n_fail++; $display("FAIL two_word1: got %h want 00a00113", tb_mem[1]); end
        n_checks++; if (imem_addr !== 4'h1 || imem_wdata !== 32'h00A00113) begin n_fail++; $display("FAIL two_hold: got addr=%h data=%h want 1/00a00113", imem_addr, imem_wdata); end
    endtask

    task automatic test_bad_checksum();
        we_cnt    = 0;
        tb_mem[0] = 32'h0;
        tb_mem[1] = 32'h0;
        send(8'hA5, 0);
        n_checks++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL bad_ck_reenter: got cpu_reset=%b done=%b want 1/0", cpu_reset, done); end
        send(8'h02, 0);
        send(8'h93, 0); send(8'h00, 0); send(8'h50, 0); send(8'h00, 0);
        send(8'h13, 0); send(8'h01, 0); send(8'hA0, 0); send(8'h00, 0);
        send(8'h98, 0);
        n_checks++; if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL bad_ck_status: got err=%b done=%b cpu_reset=%b want 1/0/1", error, done, cpu_reset); end
        tick(2);
        n_checks++; if (we_cnt !== 2) begin n_fail++; $display("FAIL bad_ck_we_cnt: got %0d want 2", we_cnt); end
        n_checks++; if (tb_mem[1] !== 32'h00A00113) begin n_fail++; $display("FAIL bad_ck_word1: got %h want 00a00113", tb_mem[1]); end
    endtask

    task automatic test_bad_count();
        we_cnt = 0;
        send(8'hA5, 0); send(8'h00, 0);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL cnt_zero_err: got %b want 1", error); end
        send(8'hA5, 0);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL cnt_sync_clr: got err=%b want 0", error); end
        send(8'h11, 0);
        n_checks++; if (error !== 1'b1 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL cnt_big_err: got err=%b cpu_reset=%b want 1/1", error, cpu_reset); end
        send(8'hA5, 0); send(8'h01, 0);
        send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 0);
        send(8'h14, 0);
        n_checks++; if (done !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL cnt_recover: got done=%b err=%b want 1/0", done, error); end
        tick(2);
        n_checks++; if (we_cnt !== 1) begin n_fail++; $display("FAIL cnt_we_cnt: got %0d want 1", we_cnt); end
        n_checks++; if (tb_mem[0] !== 32'h12345678) begin n_fail++; $display("FAIL cnt_word0: got %h want 12345678", tb_mem[0]); end
    endtask

    task automatic test_full_depth();
        we_cnt = 0;
        send(8'hA5, 0); send(8'h10, 0);
        for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < 4; b++) send(8'(w), 0);
        end
        send(8'hE0, 0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b want 1", done); end
        tick(2);
        n_checks++; if (we_cnt !== 16) begin n_fail++; $display("FAIL full_we_cnt: got %0d want 16", we_cnt); end
        n_checks++; if (tb_mem[0] !== 32'h00000000) begin n_fail++; $display("FAIL full_word0: got %h want 00000000", tb_mem[0]); end
        n_checks++; if (tb_mem[15] !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL full_word15: got %h want 0f0f0f0f", tb_mem[15]); end
    endtask

    task automatic test_stall_garbage();
        send(8'h3C, 0); send(8'hFF, 0);
        n_checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin n_fail++; $display("FAIL stall_garbage_done: got done=%b cpu_reset=%b want 1/0", done, cpu_reset); end
        we_cnt    = 0;
        tb_mem[0] = 32'h0;
        tb_mem[1] = 32'h0;
        send_two_word_body(5);
        n_checks++; if (done !== 1'b0 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL stall_mid: got done=%b cpu_reset=%b want 0/1", done, cpu_reset); end
        send(8'h97, 0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b want 1", done); end
        tick(2);
        n_checks++; if (we_cnt !== 2) begin n_fail++; $display("FAIL stall_we_cnt: got %0d want 2", we_cnt); end
        n_checks++; if (tb_mem[0] !== 32'h00500093 || tb_mem[1] !== 32'h00A00113) begin n_fail++; $display("FAIL stall_words: got %h %h want 00500093 00a00113", tb_mem[0], tb_mem[1]); end
    endtask

    task automatic test_timeout();
        we_cnt = 0;
        send(8'hA5, 0); send(8'h01, 0); send(8'h93, 0);
`ifdef LOADER_TIMEOUT_EN
        tick(9);
        n_checks++; if (error !== 1'b1 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL tmo_error: got err=%b cpu_reset=%b want 1/1", error, cpu_reset); end
        n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL tmo_we_cnt: got %0d want 0", we_cnt); end
        send(8'hA5, 0); send(8'h01, 0); send(8'h93, 0);
`else
        tick(20);
        n_checks++; if (error !== 1'b0 || done !== 1'b0 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL hold_status: got err=%b done=%b cpu_reset=%b want 0/0/1", error, done, cpu_reset); end
        n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL hold_we_cnt: got %0d want 0", we_cnt); end
`endif
        send(8'h00, 0); send(8'h50, 0); send(8'h00, 0);
        send(8'hE3, 0);
        n_checks++; if (done !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL tail_done: got done=%b err=%b want 1/0", done, error); end
        tick(2);
        n_checks++; if (we_cnt !== 1 || tb_mem[0] !== 32'h00500093) begin n_fail++; $display("FAIL tail_write: got cnt=%0d word=%h want 1/00500093", we_cnt, tb_mem[0]); end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_bad_checksum();
        test_bad_count();
        test_full_depth();
        test_stall_garbage();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
